acc_alu_seq: RTL and testbench
==============================

// Module: acc_alu_seq
// PURPOSE
//  Sequential ALU stage directly upstream of the 8-bit accumulator register.
//  Takes current accumulator value (acc_val, wired from acc_out) and operand,
//  computes result over 1..WIDTH+1 cycles, drives acc_in plus one-cycle ld pulse.
//  Start/busy handshake toward the controller; zero/carry flags for branching.
// PARAMETERS
//  WIDTH   8   datapath width; acc_val, operand, acc_in all WIDTH bits
//  SHW     3   shift-amount width; shift count = operand[SHW-1:0]
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      asynchronous, active-low reset (0 = reset)
//  start    in   1      request; sampled only in IDLE
//  op       in   3      opcode, captured with start
//  acc_val  in   WIDTH  accumulator current value (A), captured with start
//  operand  in   WIDTH  second operand (B), captured with start
//  busy     out  1      high in every state except IDLE
//  ld       out  1      one-cycle load strobe to accumulator
//  acc_in   out  WIDTH  result; valid while ld=1, held afterwards
//  carry    out  1      carry/borrow flag, updated with ld
//  zero     out  1      1 when result==0, updated with ld
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; busy, ld, acc_in, carry, zero all 0.
//  Reset mid-operation aborts immediately; no ld issued; result discarded.
//  Opcodes: 000 PASS B; 001 ADD A+B; 010 SUB A-B; 011 AND; 100 OR; 101 XOR;
//   110 MUL (shift-add, low WIDTH bits); 111 SHL A by operand[SHW-1:0], logical.
//  FSM: IDLE -> EXEC (ops 000-101) | MUL (110) | SHIFT (111) -> DONE -> IDLE.
//  Edge T0: start=1 in IDLE -> op, A, B latched; busy=1 after T0.
//  EXEC: result registered at T1; DONE cycle follows (ld=1 between T1 and T2).
//  MUL: one multiplier bit per cycle, WIDTH iterations; ld after T0+WIDTH+1.
//  SHIFT: one bit per cycle, count k; ld after T0+k+1; k=0 -> result=A, ld after T1.
//  DONE: ld=1 exactly one cycle, busy still 1; next edge -> IDLE, ld=0, busy=0.
//  start while busy (incl. DONE cycle) ignored, not queued.
//  Back-to-back: start held high -> new op accepted first IDLE cycle after DONE.
//  Width rules: all arithmetic mod 2^WIDTH.
//   ADD carry = carry-out; SUB carry = borrow (A<B unsigned).
//   MUL carry = OR of discarded high WIDTH bits (overflow).
//   SHL carry = last bit shifted out (0 if k=0); PASS/logic ops carry=0.
//  acc_in, carry, zero change only on the cycle ld rises; held otherwise.
//  Latched A/B unaffected by acc_val/operand changes during busy.
// TESTING
//  1 ADD A=8'hAA B=8'h55 -> acc_in=8'hFF, carry=0, zero=0, ld 1 cycle after T1.
//  2 ADD A=8'hF0 B=8'h10 -> 8'h00, carry=1, zero=1; SUB A=8'h0F B=8'h10 -> 8'hFF, carry=1.
//  3 MUL 8'h0F*8'h11 -> 8'hFF carry=0; 8'h10*8'h10 -> 8'h00 carry=1 zero=1;
//    ld exactly WIDTH+1=9 edges after T0, busy high throughout.
//  4 SHL A=8'h81 k=1 -> 8'h02 carry=1 (latency 2); k=0 -> 8'h81 carry=0 (latency 1);
//    k=7 -> 8'h80 latency 8.
//  5 start pulsed during MUL and during DONE with op=ADD -> ignored, single ld, result
//    unchanged; start held high -> second op begins the cycle after return to IDLE.
//  6 rst=0 at 4th MUL cycle -> busy, ld, acc_in, flags 0 immediately; no ld after
//    release; new ADD after release completes normally with chained accumulator.

Source files
------------

// File: rtl/acc_alu_if.sv
// Controller/accumulator-side bundle for the sequential ALU stage.
// The master issues start/op/operands; the slave returns status and the result.
interface acc_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] acc_val;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic             ld;
  logic [WIDTH-1:0] acc_in;
  logic             carry;
  logic             zero;

  modport master (
    output start, op, acc_val, operand,
    input  busy, ld, acc_in, carry, zero
  );

  modport slave (
    input  start, op, acc_val, operand,
    output busy, ld, acc_in, carry, zero
  );
endinterface

// File: rtl/acc_alu_seq.sv
// Sequential ALU stage feeding the accumulator register.
// Single-cycle ops, shift-add multiply and bit-serial left shift, one ld pulse each.
module acc_alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input logic   clk,
  input logic   rst,
  acc_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL,
    SHIFT,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] a_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt_q;
  logic               c_q;

  logic [WIDTH-1:0]   acc_in_q;
  logic               carry_q;
  logic               zero_q;

  logic               accept;
  logic               fin;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [CW-1:0]      k;

  assign accept = (state_q == IDLE) && bus.start;
  assign k      = CW'(b_q[SHW-1:0]);
  assign sum    = {1'b0, a_q[WIDTH-1:0]} + {1'b0, b_q};
  // Top bit of the widened difference is the unsigned borrow.
  assign dif    = {1'b0, a_q[WIDTH-1:0]} - {1'b0, b_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (bus.op)
            OP_MUL:  state_d = MUL;
            OP_SHL:  state_d = SHIFT;
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC, MUL, SHIFT: begin
        if (fin) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fin   = 1'b0;
    res   = '0;
    res_c = 1'b0;
    unique case (state_q)
      EXEC: begin
        fin = 1'b1;
        unique case (op_q)
          OP_PASS: res = b_q;
          OP_ADD: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
          end
          OP_SUB: begin
            res   = dif[WIDTH-1:0];
            res_c = dif[WIDTH];
          end
          OP_AND:  res = a_q[WIDTH-1:0] & b_q;
          OP_OR:   res = a_q[WIDTH-1:0] | b_q;
          OP_XOR:  res = a_q[WIDTH-1:0] ^ b_q;
          default: res = '0;
        endcase
      end
      MUL: begin
        fin   = (cnt_q == CW'(WIDTH));
        res   = p_q[WIDTH-1:0];
        res_c = |p_q[2*WIDTH-1:WIDTH];
      end
      SHIFT: begin
        fin   = (cnt_q == k);
        res   = a_q[WIDTH-1:0];
        res_c = c_q;
      end
      default: begin
        fin = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      c_q   <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.op;
      a_q   <= {{WIDTH{1'b0}}, bus.acc_val};
      b_q   <= bus.operand;
      p_q   <= '0;
      cnt_q <= '0;
      c_q   <= 1'b0;
    end else if (state_q == MUL && !fin) begin
      if (b_q[0]) p_q <= p_q + a_q;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == SHIFT && !fin) begin
      a_q   <= a_q << 1;
      c_q   <= a_q[WIDTH-1];
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Result and flags move only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_in_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else if (fin) begin
      acc_in_q <= res;
      carry_q  <= res_c;
      zero_q   <= (res == '0);
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.ld     = (state_q == DONE);
  assign bus.acc_in = acc_in_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed bench for acc_alu_seq: vector table plus multi-cycle sequences.
// Expected values are hand-computed constants.
module tb_acc_alu_seq;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  acc_alu_if #(.WIDTH(8)) bus ();

  acc_alu_seq #(
    .WIDTH(8),
    .SHW  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  vec_t v [15];

  int n_cmp = 0;
  int n_bad = 0;
  int nld;
  int lat;
  logic [7:0] acc_m;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic c,
                       input logic z, input int elat);
    int n;
    logic busy_ok;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.acc_val = a;
    bus.operand = b;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.op      = ~op;
    bus.acc_val = ~a;
    bus.operand = ~b;
    chk({nm, " busy_after_t0"}, {31'd0, bus.busy}, 32'd1);
    n = 0;
    busy_ok = 1'b1;
    do begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end while (!bus.ld && n < 40);
    chk({nm, " latency"}, n, elat);
    chk({nm, " busy_held"}, {31'd0, busy_ok & bus.busy}, 32'd1);
    chk({nm, " acc_in"}, {24'd0, bus.acc_in}, {24'd0, r});
    chk({nm, " carry"}, {31'd0, bus.carry}, {31'd0, c});
    chk({nm, " zero"}, {31'd0, bus.zero}, {31'd0, z});
    @(negedge clk);
    chk({nm, " ld_one_cycle"}, {31'd0, bus.ld}, 32'd0);
    chk({nm, " idle_after"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, " acc_in_held"}, {24'd0, bus.acc_in}, {24'd0, r});
  endtask

  initial begin
    v[0]  = '{OP_ADD,  8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1};
    v[1]  = '{OP_ADD,  8'hF0, 8'h10, 8'h00, 1'b1, 1'b1, 1};
    v[2]  = '{OP_SUB,  8'h0F, 8'h10, 8'hFF, 1'b1, 1'b0, 1};
    v[3]  = '{OP_MUL,  8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 9};
    v[4]  = '{OP_MUL,  8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 9};
    v[5]  = '{OP_SHL,  8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 2};
    v[6]  = '{OP_SHL,  8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1};
    v[7]  = '{OP_SHL,  8'h81, 8'h07, 8'h80, 1'b0, 1'b0, 8};
    v[8]  = '{OP_PASS, 8'h12, 8'h3C, 8'h3C, 1'b0, 1'b0, 1};
    v[9]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
    v[10] = '{OP_OR,   8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1};
    v[11] = '{OP_XOR,  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    v[12] = '{OP_SUB,  8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1};
    v[13] = '{OP_SHL,  8'hC0, 8'hF9, 8'h80, 1'b1, 1'b0, 2};
    v[14] = '{OP_MUL,  8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 9};

    bus.start   = 1'b0;
    bus.op      = OP_PASS;
    bus.acc_val = 8'h00;
    bus.operand = 8'h00;

    #12;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst ld", {31'd0, bus.ld}, 32'd0);
    chk("rst acc_in", {24'd0, bus.acc_in}, 32'd0);
    chk("rst carry", {31'd0, bus.carry}, 32'd0);
    chk("rst zero", {31'd0, bus.zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      do_op($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b,
            v[i].r, v[i].c, v[i].z, v[i].lat);
    end

    // Starts during MUL and during DONE must be dropped.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = OP_MUL;
    bus.acc_val = 8'h0F;
    bus.operand = 8'h11;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    nld = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus.start   = 1'b1;
        bus.op      = OP_ADD;
        bus.acc_val = 8'h01;
        bus.operand = 8'h01;
      end else if (i == 4) begin
        bus.start = 1'b0;
      end
      if (bus.ld) begin
        nld++;
        if (lat == 0) lat = i;
        bus.start = 1'b1;
        bus.op    = OP_ADD;
      end else if (i > 4) begin
        bus.start = 1'b0;
      end
    end
    chk("ign ld_count", nld, 1);
    chk("ign latency", lat, 9);
    chk("ign acc_in", {24'd0, bus.acc_in}, 32'hFF);
    chk("ign idle", {31'd0, bus.busy}, 32'd0);

    // Start held high: second op accepted right after returning to IDLE.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = OP_ADD;
    bus.acc_val = 8'h01;
    bus.operand = 8'h02;
    @(posedge clk);
    @(negedge clk);
    bus.op      = OP_SUB;
    bus.acc_val = 8'h05;
    bus.operand = 8'h03;
    @(negedge clk);
    chk("held ld1", {31'd0, bus.ld}, 32'd1);
    chk("held res1", {24'd0, bus.acc_in}, 32'h03);
    @(negedge clk);
    chk("held idle_gap", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("held accepted", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("held ld2", {31'd0, bus.ld}, 32'd1);
    chk("held res2", {24'd0, bus.acc_in}, 32'h02);
    chk("held carry2", {31'd0, bus.carry}, 32'd0);

    // Reset in the middle of a multiply.
    do_op("pre_rst", OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = OP_MUL;
    bus.acc_val = 8'hFF;
    bus.operand = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst ld", {31'd0, bus.ld}, 32'd0);
    chk("midrst acc_in", {24'd0, bus.acc_in}, 32'd0);
    chk("midrst carry", {31'd0, bus.carry}, 32'd0);
    chk("midrst zero", {31'd0, bus.zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    nld = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.ld || bus.busy) nld++;
    end
    chk("midrst no_ld", nld, 0);

    acc_m = 8'h00;
    do_op("chain1", OP_ADD, acc_m, 8'h05, 8'h05, 1'b0, 1'b0, 1);
    acc_m = 8'h05;
    do_op("chain2", OP_ADD, acc_m, 8'hFB, 8'h00, 1'b1, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
